// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM state encodings and
// default timing constants.
package uart_tx_pkg;

  // 2-bit FSM encoding; values kept identical to the original state defines
  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

  // 50 MHz system clock / 115200 baud
  localparam int unsigned UART_CLKS_PER_BIT = 434;

  // Data bits per frame (8N1 / 8N2)
  localparam int unsigned UART_DATA_BITS = 8;

  // Index of the last data bit, as a 3-bit value
  localparam logic [2:0] UART_LAST_BIT = 3'(UART_DATA_BITS - 1);

  // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit)
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// terminal count. A synchronous clear restarts the bit period.
module uart_baud_tick
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] baud_cnt;

  // Terminal count of the current bit period
  always_comb begin
    tick = en && (baud_cnt == TERM);
  end

  // Bit-period counter, wraps to zero on terminal count
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      baud_cnt <= '0;
    end else if (clear) begin
      baud_cnt <= '0;
    end else if (en) begin
      if (baud_cnt == TERM) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Serial UART transmitter fed by the memory-mapped UART window.
// A rising edge on uart_te while idle sends uart_txd as one 8N1/8N2 frame,
// LSB first, on a registered, idle-high txd line.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       uart_te,
  input  logic [7:0] uart_txd,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  // Last value of the 1-bit stop counter (0 for one stop bit, 1 for two)
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_t state;
  logic        te_q;
  logic [7:0]  shift;
  logic [2:0]  bit_idx;
  logic        stop_cnt;
  logic        trigger;
  logic        tick;
  logic        baud_en;

  // Start a frame only on a fresh rising edge of uart_te while idle.
  // te_q resets high so a level held through reset release is not an edge.
  always_comb begin
    trigger = uart_te && !te_q && (state == UART_IDLE);
    baud_en = (state != UART_IDLE);
  end

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .CLK  (CLK),
    .RST  (RST),
    .clear(trigger),
    .en   (baud_en),
    .tick (tick)
  );

  // Frame sequencer: edge detect, shift register and registered line outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= UART_IDLE;
      txd      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      te_q     <= 1'b1;
      shift    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      te_q <= uart_te;
      done <= 1'b0;
      unique case (state)
        UART_IDLE: begin
          if (trigger) begin
            shift    <= uart_txd;
            state    <= UART_START;
            txd      <= 1'b0;
            busy     <= 1'b1;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
          end
        end
        UART_START: begin
          if (tick) begin
            state <= UART_DATA;
            txd   <= shift[0];
          end
        end
        UART_DATA: begin
          if (tick) begin
            if (bit_idx == UART_LAST_BIT) begin
              state   <= UART_STOP;
              txd     <= 1'b1;
              bit_idx <= '0;
            end else begin
              shift   <= shift >> 1;
              txd     <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        UART_STOP: begin
          // Stop period spans STOP_BITS bit periods; the 1-bit counter
          // selects which of them is the last
          if (tick) begin
            if (stop_cnt == STOP_LAST) begin
              state    <= UART_IDLE;
              busy     <= 1'b0;
              done     <= 1'b1;
              stop_cnt <= 1'b0;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= UART_IDLE;
        end
      endcase
    end
  end

endmodule
